// File: rtl/mod_pow_pkg.sv
// mod_pow_pkg: shared FSM encoding, default operand width and the
// mod_mul pass-length helper for the modular-exponentiation engine.
package mod_pow_pkg;

    localparam int MOD_POW_WIDTH = 512;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_REDUCE,
        ST_STEP,
        ST_DONE
    } state_t;

    // One interleaved shift-add-reduce pass consumes one multiplier bit per cycle.
    function automatic int mod_mul_cycles(input int width);
        return width;
    endfunction

endpackage

// File: rtl/mod_mul.sv
// mod_mul: p = a*b mod m by interleaved MSB-first shift-add, one b bit per cycle.
// The first bit is taken from the ports in the start cycle, so a pass is exactly WIDTH cycles.
module mod_mul
    import mod_pow_pkg::*;
#(
    parameter int WIDTH = MOD_POW_WIDTH
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_INIT = CW'(mod_mul_cycles(WIDTH) - 2);

    logic [WIDTH-1:0] r_q, a_q, b_q, m_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [WIDTH-1:0] r_cur, a_cur, m_cur, r_next;
    logic             bit_cur;
    logic [WIDTH+1:0] sum, m_ext, red1;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        r_cur   = r_q;
        a_cur   = a_q;
        m_cur   = m_q;
        bit_cur = b_q[WIDTH-1];
        if (start) begin
            r_cur   = '0;
            a_cur   = a;
            m_cur   = m;
            bit_cur = b[WIDTH-1];
        end
        // 2r + a < 3m, so two conditional subtractions always land below m.
        sum    = {1'b0, r_cur, 1'b0} + (bit_cur ? {2'b00, a_cur} : '0);
        m_ext  = {2'b00, m_cur};
        red1   = (sum >= m_ext) ? sum - m_ext : sum;
        r_next = WIDTH'((red1 >= m_ext) ? red1 - m_ext : red1);
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            r_q    <= r_next;
            a_q    <= a;
            b_q    <= b << 1;
            m_q    <= m;
            cnt_q  <= CNT_INIT;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            r_q    <= r_next;
            b_q    <= b_q << 1;
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= (cnt_q != '0);
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign p    = r_next;

endmodule

// File: rtl/mod_pow.sv
// mod_pow: free-running response = Number^Exponent mod Modules, right-to-left binary method.
// Define MOD_POW_EARLY_EXIT_EN to stop squaring once the shifted exponent reaches zero.
module mod_pow
    import mod_pow_pkg::*;
#(
    parameter int WIDTH = MOD_POW_WIDTH
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] Number,
    input  logic [WIDTH-1:0] Exponent,
    input  logic [WIDTH-1:0] Modules,
    output logic [WIDTH-1:0] response,
    output logic             res_done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, e_q, m_q, acc_q, base_q;
    logic             pass_active_q;
`ifndef MOD_POW_EARLY_EXIT_EN
    localparam int    PW = $clog2(WIDTH + 1);
    logic [PW-1:0]    pass_cnt_q;
`endif

    logic             mul_start, sq_start, mul_done, sq_done, pass_done;
    logic [WIDTH-1:0] mul_a, mul_b, mul_p, sq_p, acc_step, result_d;
    logic             small_mod, last_pass;

    assign small_mod = (Modules[WIDTH-1:1] == '0);
    assign acc_step  = e_q[0] ? mul_p : acc_q;
    assign pass_done = (state_q == ST_STEP) ? (mul_done && sq_done) : mul_done;

`ifdef MOD_POW_EARLY_EXIT_EN
    assign last_pass = (e_q[WIDTH-1:1] == '0);
`else
    assign last_pass = (pass_cnt_q == PW'(WIDTH - 1));
`endif

    always_ff @(posedge aclk) begin
        if (areset) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:   state_d = small_mod ? ST_DONE : ST_REDUCE;
            ST_REDUCE: if (pass_done) begin
`ifdef MOD_POW_EARLY_EXIT_EN
                state_d = (e_q == '0) ? ST_DONE : ST_STEP;
`else
                state_d = ST_STEP;
`endif
            end
            ST_STEP:   if (pass_done && last_pass) state_d = ST_DONE;
            ST_DONE:   state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        sq_start  = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        result_d  = acc_q;
        res_done  = 1'b0;
        unique case (state_q)
            ST_LOAD:   result_d = '0;
            ST_REDUCE: begin
                mul_start = !pass_active_q;
                mul_a     = WIDTH'(1);
                mul_b     = n_q;
            end
            ST_STEP: begin
                // The multiply runs even for a 0 bit so timing never depends on the exponent.
                mul_start = !pass_active_q;
                sq_start  = !pass_active_q;
                mul_a     = acc_q;
                mul_b     = base_q;
                result_d  = acc_step;
            end
            ST_DONE:   res_done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            n_q           <= '0;
            e_q           <= '0;
            m_q           <= '0;
            acc_q         <= '0;
            base_q        <= '0;
            response      <= '0;
            pass_active_q <= 1'b0;
`ifndef MOD_POW_EARLY_EXIT_EN
            pass_cnt_q    <= '0;
`endif
        end else begin
            if (mul_start)      pass_active_q <= 1'b1;
            else if (pass_done) pass_active_q <= 1'b0;

            unique case (state_q)
                ST_LOAD: begin
                    n_q    <= Number;
                    e_q    <= Exponent;
                    m_q    <= Modules;
                    acc_q  <= small_mod ? '0 : WIDTH'(1);
                    base_q <= '0;
`ifndef MOD_POW_EARLY_EXIT_EN
                    pass_cnt_q <= '0;
`endif
                end
                ST_REDUCE: if (pass_done) base_q <= mul_p;
                ST_STEP: if (pass_done) begin
                    acc_q  <= acc_step;
                    base_q <= sq_p;
                    e_q    <= e_q >> 1;
`ifndef MOD_POW_EARLY_EXIT_EN
                    pass_cnt_q <= pass_cnt_q + PW'(1);
`endif
                end
                default: ;
            endcase

            // Load the result on entry to DONE so it is valid during the res_done cycle.
            if (state_d == ST_DONE) response <= result_d;
        end
    end

    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .aclk   (aclk),
        .areset (areset),
        .start  (mul_start),
        .a      (mul_a),
        .b      (mul_b),
        .m      (m_q),
        .p      (mul_p),
        .done   (mul_done)
    );

    mod_mul #(.WIDTH(WIDTH)) u_sq (
        .aclk   (aclk),
        .areset (areset),
        .start  (sq_start),
        .a      (base_q),
        .b      (base_q),
        .m      (m_q),
        .p      (sq_p),
        .done   (sq_done)
    );

endmodule

// File: tb/tb_mod_pow.sv
// tb_mod_pow: scoreboard bench for mod_pow at WIDTH = 16; expected results and
// cycle latencies are queued at stimulus time and checked by an independent monitor.
module tb_mod_pow;

    localparam int W = 16;
`ifdef MOD_POW_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [W-1:0] number = '0, exponent = '0, modules = '0;
    logic [W-1:0] response;
    logic         res_done;

    mod_pow #(.WIDTH(W)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .Number   (number),
        .Exponent (exponent),
        .Modules  (modules),
        .response (response),
        .res_done (res_done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string        name;
        logic [W-1:0] n, e, m, r;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] resp;
        int           lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int bit_len(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    // Inclusive cycle count LOAD..DONE, which is also the res_done-to-res_done period.
    function automatic int exp_lat(input logic [W-1:0] e, input logic [W-1:0] m);
        int k;
        if (m <= 1) return 2;
        k = EARLY ? bit_len(e) : W;
        return 2 + W * (1 + k);
    endfunction

    task automatic add_vec(input string name, input int n, input int e, input int m, input int r);
        vec_t v;
        v.name = name;
        v.n = W'(n);
        v.e = W'(e);
        v.m = W'(m);
        v.r = W'(r);
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        exp_t x;
        number   = v.n;
        exponent = v.e;
        modules  = v.m;
        x.name = v.name;
        x.resp = v.r;
        x.lat  = exp_lat(v.e, v.m);
        sb_q.push_back(x);
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge aclk);
            if (res_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: res_done absent for 2000 cycles, expected a pulse");
            finish_tb();
        end
    endtask

    // Monitor: pops one expectation per res_done pulse and checks value and period.
    always @(negedge aclk) begin
        exp_t x;
        if (areset) begin
            last_cyc <= cyc;
        end else if (res_done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: response %0d, expected no pulse", response);
            end else begin
                x = sb_q.pop_front();
                check({x.name, "_response"}, 32'(response), 32'(x.resp));
                check({x.name, "_latency"}, cyc - last_cyc, x.lat);
            end
            last_cyc <= cyc;
        end
    end

    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        finish_tb();
    end

    initial begin
        vec_t post;
        add_vec("v16_22_11",    16,    22,    11,      3);
        add_vec("v17_24_13",    17,    24,    13,      1);
        add_vec("v18_26_15",    18,    26,    15,      9);
        add_vec("exp_zero",      5,     0,     7,      1);
        add_vec("mod_one",       5,     9,     1,      0);
        add_vec("mod_zero",      5,     9,     0,      0);
        add_vec("big_base_p",   65535,  3, 65521,   2744);
        add_vec("big_base_c",   65535,  3,  1003,    442);
        add_vec("max_mod",      65534,  2, 65535,      1);
        add_vec("full_exp",      3, 65535,     2,      1);
        add_vec("mod_two_zero",  4,     5,     2,      0);
        add_vec("lat_e5",        2,     5,   100,     32);

        apply(vecs[0]);
        repeat (3) @(posedge aclk);
        #1;
        check("reset_response", 32'(response), 0);
        check("reset_res_done", 32'(res_done), 0);
        areset = 1'b0;

        // Each new operand set is applied in the res_done cycle, ready for the next LOAD.
        for (int i = 1; i < vecs.size(); i++) begin
            wait_done();
            apply(vecs[i]);
        end
        wait_done();

        // Abort a computation mid-STEP with a one-cycle reset; no pulse may follow.
        number   = 16'd16;
        exponent = 16'd22;
        modules  = 16'd11;
        repeat (40) @(posedge aclk);
        #1 areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        check("abort_response", 32'(response), 0);
        check("abort_res_done", 32'(res_done), 0);

        post.name = "after_reset";
        post.n = 16'd17;
        post.e = 16'd24;
        post.m = 16'd13;
        post.r = 16'd1;
        apply(post);
        wait_done();

        @(negedge aclk);
        check("scoreboard_drained", sb_q.size(), 0);
        finish_tb();
    end

endmodule
